// File: rtl/throw_ctrl.sv
// rtl/throw_ctrl.sv - local-player throw generator: charges power while held, launches on release, steps flight per frame
`timescale 1ns/1ps
module throw_ctrl #(
    parameter logic [2:0] MY_TURN   = 3'd1,
    parameter int         X0        = 100,
    parameter int         Y0        = 400,
    parameter int         GROUND_Y  = 440,
    parameter int         X_MAX     = 1023,
    parameter bit         DIR       = 1'b1,
    parameter int         GRAVITY   = 1,
    parameter logic [5:0] POWER_MAX = 6'd63
) (
    input  logic        clk60MHz,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [2:0]  turn,
    input  logic        mouse_left,
    output logic        throw_flag,
    output logic        land_flag,
    output logic        proj_active,
    output logic [10:0] proj_x,
    output logic [9:0]  proj_y,
    output logic [5:0]  power
);

    typedef enum logic [1:0] {S_IDLE, S_CHARGE, S_FLIGHT, S_DONE} state_t;

    state_t             r_state;
    logic               r_prev;
    logic signed [11:0] r_x;
    logic signed [10:0] r_y;
    logic        [4:0]  r_vx;
    logic signed [10:0] r_vy;
    logic        [5:0]  r_power;
    logic               r_throw;
    logic               r_land;
    logic               r_active;
    logic        [10:0] r_px;
    logic        [9:0]  r_py;

    logic               w_rise;
    logic               w_fall;
    logic               w_my_turn;
    logic signed [11:0] w_nx;
    logic signed [10:0] w_ny;
    logic signed [10:0] w_nvy;
    logic               w_ground;
    logic               w_out;
    logic        [10:0] w_cx;
    logic        [9:0]  w_cy;
    logic        [4:0]  w_launch_vx;
    logic signed [10:0] w_launch_vy;

    assign w_rise    = mouse_left & ~r_prev;
    assign w_fall    = ~mouse_left & r_prev;
    assign w_my_turn = (turn == MY_TURN);

    assign w_nx  = DIR ? (r_x + $signed({7'd0, r_vx})) : (r_x - $signed({7'd0, r_vx}));
    assign w_ny  = r_y + r_vy;
    assign w_nvy = r_vy + $signed(11'(GRAVITY));

    assign w_ground = (w_ny >= $signed(11'(GROUND_Y)));
    assign w_out    = (w_nx < 12'sd0) || (w_nx > $signed(12'(X_MAX)));

    // Clamp before truncation so the narrow outputs never show a wrapped value
    assign w_cx = (w_nx < 12'sd0) ? 11'd0 :
                  (w_nx > $signed(12'(X_MAX))) ? 11'(X_MAX) : w_nx[10:0];
    assign w_cy = w_ground ? 10'(GROUND_Y) :
                  (w_ny < 11'sd0) ? 10'd0 : w_ny[9:0];

    assign w_launch_vx = {1'b0, r_power[5:2]} + 5'd1;
    assign w_launch_vy = 11'sd0 - $signed({6'd0, r_power[5:1]});

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_prev   <= 1'b0;
            r_x      <= 12'(X0);
            r_y      <= 11'(Y0);
            r_vx     <= 5'd0;
            r_vy     <= 11'sd0;
            r_power  <= 6'd0;
            r_throw  <= 1'b0;
            r_land   <= 1'b0;
            r_active <= 1'b0;
            r_px     <= 11'(X0);
            r_py     <= 10'(Y0);
        end else begin
            r_prev  <= mouse_left;
            r_throw <= 1'b0;
            r_land  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise && w_my_turn) begin
                        r_state <= S_CHARGE;
                        r_power <= 6'd0;
                    end
                end
                S_CHARGE: begin
                    // Losing the turn outranks a release in the same cycle
                    if (!w_my_turn) begin
                        r_state <= S_IDLE;
                        r_power <= 6'd0;
                    end else if (w_fall) begin
                        r_state  <= S_FLIGHT;
                        r_throw  <= 1'b1;
                        r_active <= 1'b1;
                        r_x      <= 12'(X0);
                        r_y      <= 11'(Y0);
                        r_px     <= 11'(X0);
                        r_py     <= 10'(Y0);
                        r_vx     <= w_launch_vx;
                        r_vy     <= w_launch_vy;
                    end else if (frame_tick && (r_power < POWER_MAX)) begin
                        r_power <= r_power + 6'd1;
                    end
                end
                S_FLIGHT: begin
                    if (frame_tick) begin
                        r_x  <= w_nx;
                        r_y  <= w_ny;
                        r_vy <= w_nvy;
                        r_px <= w_cx;
                        r_py <= w_cy;
                        if (w_ground || w_out) begin
                            r_state  <= S_DONE;
                            r_land   <= 1'b1;
                            r_active <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign throw_flag  = r_throw;
    assign land_flag   = r_land;
    assign proj_active = r_active;
    assign proj_x      = r_px;
    assign proj_y      = r_py;
    assign power       = r_power;

endmodule

// File: tb/tb_throw_ctrl.sv
// tb/tb_throw_ctrl.sv - randomized and directed bench for throw_ctrl against a behavioural model
`timescale 1ns/1ps
module tb_throw_ctrl;

    logic        clk60MHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [2:0]  turn = 3'd1;
    logic        mouse_left = 1'b0;
    logic        throw_flag;
    logic        land_flag;
    logic        proj_active;
    logic [10:0] proj_x;
    logic [9:0]  proj_y;
    logic [5:0]  power;

    int n_checks = 0;
    int n_err = 0;
    int n_throws = 0;
    int n_lands = 0;

    throw_ctrl dut (
        .clk60MHz   (clk60MHz),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .turn       (turn),
        .mouse_left (mouse_left),
        .throw_flag (throw_flag),
        .land_flag  (land_flag),
        .proj_active(proj_active),
        .proj_x     (proj_x),
        .proj_y     (proj_y),
        .power      (power)
    );

    always #5 clk60MHz = ~clk60MHz;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks the throw as a sequence of phases with plain integers
    bit m_prev, m_charging, m_flying, m_settle, m_rise, m_fall, m_hit_ground, m_off_screen;
    int m_power, m_x, m_y, m_vx, m_vy;
    int e_throw, e_land, e_active, e_px, e_py, e_power;

    always @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = 0; m_charging = 0; m_flying = 0; m_settle = 0;
            m_power = 0; m_x = 100; m_y = 400; m_vx = 0; m_vy = 0;
            e_throw = 0; e_land = 0; e_active = 0; e_px = 100; e_py = 400; e_power = 0;
        end else begin
            m_rise = mouse_left && !m_prev;
            m_fall = !mouse_left && m_prev;
            e_throw = 0;
            e_land = 0;
            if (m_flying) begin
                if (frame_tick) begin
                    m_x = m_x + m_vx;
                    m_y = m_y + m_vy;
                    m_vy = m_vy + 1;
                    m_hit_ground = (m_y >= 440);
                    m_off_screen = (m_x < 0) || (m_x > 1023);
                    e_px = (m_x < 0) ? 0 : (m_x > 1023) ? 1023 : m_x;
                    e_py = m_hit_ground ? 440 : (m_y < 0) ? 0 : m_y;
                    if (m_hit_ground || m_off_screen) begin
                        m_flying = 0; m_settle = 1; e_land = 1; e_active = 0;
                    end
                end
            end else if (m_settle) begin
                m_settle = 0;
            end else if (m_charging) begin
                if (turn != 3'd1) begin
                    m_charging = 0; m_power = 0;
                end else if (m_fall) begin
                    m_charging = 0; m_flying = 1; e_throw = 1; e_active = 1;
                    m_x = 100; m_y = 400; e_px = 100; e_py = 400;
                    m_vx = m_power / 4 + 1;
                    m_vy = -(m_power / 2);
                end else if (frame_tick && m_power < 63) begin
                    m_power = m_power + 1;
                end
            end else if (m_rise && turn == 3'd1) begin
                m_charging = 1; m_power = 0;
            end
            m_prev = mouse_left;
            e_power = m_power;
        end
    end

    always @(negedge clk60MHz) begin
        chk("throw_flag", int'(throw_flag), e_throw);
        chk("land_flag", int'(land_flag), e_land);
        chk("proj_active", int'(proj_active), e_active);
        chk("proj_x", int'(proj_x), e_px);
        chk("proj_y", int'(proj_y), e_py);
        chk("power", int'(power), e_power);
        if (throw_flag) n_throws++;
        if (land_flag) n_lands++;
    end

    task automatic step(input bit ft, input bit ml);
        @(negedge clk60MHz);
        #1;
        frame_tick = ft;
        mouse_left = ml;
        @(posedge clk60MHz);
        #1;
    endtask

    task automatic charge(input int n);
        step(0, 1);
        for (int i = 0; i < n; i++) begin
            step(1, 1);
            step(0, 1);
        end
    endtask

    task automatic fly(output int ticks);
        ticks = 0;
        for (int i = 0; i < 400 && !land_flag; i++) begin
            step(1, 0);
            ticks++;
        end
        if (!land_flag) chk("land_timeout", 0, 1);
        step(0, 0);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int t0;
    int lands0;
    bit ml_r;

    initial begin
        repeat (3) @(negedge clk60MHz);
        chk("reset_proj_x", int'(proj_x), 100);
        chk("reset_proj_y", int'(proj_y), 400);
        chk("reset_power", int'(power), 0);
        chk("reset_active", int'(proj_active), 0);
        #1 rst_n = 1'b1;
        step(0, 0);

        turn = 3'd2;
        step(0, 1); step(1, 1); step(0, 1); step(0, 0); step(0, 0);
        chk("wrong_turn_throws", n_throws, 0);
        chk("wrong_turn_power", int'(power), 0);
        chk("wrong_turn_active", int'(proj_active), 0);
        turn = 3'd1;

        charge(20);
        step(0, 0);
        chk("normal_throw_flag", int'(throw_flag), 1);
        chk("normal_power", int'(power), 20);
        step(1, 0);
        chk("normal_tick1_x", int'(proj_x), 106);
        chk("normal_tick1_y", int'(proj_y), 390);
        fly(t0);
        chk("normal_land_tick", t0 + 1, 25);
        chk("normal_land_x", int'(proj_x), 250);
        chk("normal_land_y", int'(proj_y), 440);
        chk("normal_throw_count", n_throws, 1);
        chk("normal_power_held", int'(power), 20);

        charge(100);
        chk("sat_power", int'(power), 63);
        step(0, 0);
        step(1, 0);
        chk("sat_tick1_x", int'(proj_x), 116);
        chk("sat_tick1_y", int'(proj_y), 369);
        fly(t0);

        charge(10);
        step(1, 0);
        chk("simul_power", int'(power), 10);
        step(1, 0);
        chk("simul_tick1_x", int'(proj_x), 103);
        chk("simul_tick1_y", int'(proj_y), 395);
        fly(t0);

        charge(5);
        chk("lost_turn_power5", int'(power), 5);
        turn = 3'd2;
        step(0, 1);
        chk("lost_turn_power0", int'(power), 0);
        step(0, 0);
        step(0, 0);
        chk("lost_turn_throws", n_throws, 3);
        turn = 3'd1;

        charge(20);
        step(0, 0);
        step(1, 0); step(1, 0); step(1, 0);
        lands0 = n_lands;
        @(negedge clk60MHz);
        #1 rst_n = 1'b0;
        #2;
        chk("midreset_active", int'(proj_active), 0);
        chk("midreset_x", int'(proj_x), 100);
        chk("midreset_y", int'(proj_y), 400);
        @(negedge clk60MHz);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step(1, 0);
        chk("midreset_no_land", n_lands, lands0);

        ml_r = 0;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 19) == 0) ml_r = !ml_r;
            if ($urandom_range(0, 299) == 0)
                turn = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            step($urandom_range(0, 3) == 0, ml_r);
        end

        @(negedge clk60MHz);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
